// File: rtl/cbfp_index_align_pkg.sv
// Shared widths, lane vector types and the per-lane de-normalisation helper
// for the CBFP index alignment stage.
package cbfp_index_align_pkg;

  localparam int N     = 16;
  localparam int IDX_W = 5;
  localparam int DIN_W = 13;
  localparam int OUT_W = 16;
  localparam int DEPTH = 32;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BLK_W = 5;
  localparam int TOT_W = IDX_W + 1;
  localparam int EXT_W = DIN_W + 1;

  typedef logic [N-1:0][IDX_W-1:0] idx_vec_t;
  typedef logic [N-1:0][DIN_W-1:0] din_vec_t;
  typedef logic [N-1:0][OUT_W-1:0] dout_vec_t;
  typedef logic [TOT_W-1:0]        tot_t;

  function automatic tot_t idx_sum(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // One extra bit of headroom keeps din + 2^(tot-1) from wrapping before the shift.
  function automatic logic [OUT_W-1:0] denorm_lane(input logic [DIN_W-1:0] din, input tot_t tot);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] r;
    ext = {din[DIN_W-1], din};
    rnd = '0;
    r   = '0;
    if (tot == '0) begin
      r = ext;
    end else if (tot < TOT_W'(EXT_W)) begin
      rnd = ext + (EXT_W'(1) << (tot - TOT_W'(1)));
      r   = rnd >>> tot;
    end
    return {{(OUT_W-EXT_W){r[EXT_W-1]}}, r};
  endfunction

endpackage

// File: rtl/cbfp_index_align_if.sv
// Valid-only stream bundle between the CBFP stages and the index alignment block.
interface cbfp_index_align_if;
  import cbfp_index_align_pkg::*;

  logic             idx_valid_in;
  idx_vec_t         idx0_in;
  logic             data_valid_in;
  din_vec_t         din_i;
  din_vec_t         din_q;
  idx_vec_t         idx1_in;
  logic             valid_out;
  dout_vec_t        dout_i;
  dout_vec_t        dout_q;
  logic [BLK_W-1:0] blk_cnt;
  logic             frame_done;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output idx_valid_in, idx0_in, data_valid_in, din_i, din_q, idx1_in,
    input  valid_out, dout_i, dout_q, blk_cnt, frame_done, overflow_err, underflow_err
  );

  modport slave (
    input  idx_valid_in, idx0_in, data_valid_in, din_i, din_q, idx1_in,
    output valid_out, dout_i, dout_q, blk_cnt, frame_done, overflow_err, underflow_err
  );

endinterface

// File: rtl/cbfp_index_align_fifo.sv
// Stage-0 index vector FIFO; the head is read combinationally so a pop
// can use it in the same cycle.
module cbfp_index_align_fifo
  import cbfp_index_align_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     push,
  input  idx_vec_t wr_data,
  input  logic     pop,
  output idx_vec_t rd_data,
  output logic     full,
  output logic     empty
);

  idx_vec_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the slot the same cycle, so a full FIFO still takes a push alongside a pop.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cbfp_index_align.sv
// Pairs buffered stage-0 CBFP indices with later-stage blocks and
// de-normalises every lane by 2^-(idx0+idx1) with round-half-up.
module cbfp_index_align
  import cbfp_index_align_pkg::*;
(
  input logic               clk,
  input logic               rstn,
  cbfp_index_align_if.slave bus
);

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  logic             full;
  logic             empty;
  idx_vec_t         head;
  idx_vec_t         idx0_eff;
  dout_vec_t        res_i;
  dout_vec_t        res_q;
  logic [BLK_W-1:0] blk_nxt;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  cbfp_index_align_fifo u_fifo (
    .clk     (clk),
    .rstn    (rst_n_int),
    .push    (bus.idx_valid_in),
    .wr_data (bus.idx0_in),
    .pop     (bus.data_valid_in),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // A block arriving with nothing buffered is passed through with idx0 = 0.
  assign idx0_eff = empty ? '0 : head;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tot_t tot;
    tot   = '0;
    res_i = '0;
    res_q = '0;
    for (int k = 0; k < N; k++) begin
      tot      = idx_sum(idx0_eff[k], bus.idx1_in[k]);
      res_i[k] = denorm_lane(bus.din_i[k], tot);
      res_q[k] = denorm_lane(bus.din_q[k], tot);
    end
  end

  // blk_cnt names the block on dout, so it advances once that block has been shown.
  assign blk_nxt = bus.valid_out ? bus.blk_cnt + BLK_W'(1) : bus.blk_cnt;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      bus.valid_out     <= 1'b0;
      bus.dout_i        <= '0;
      bus.dout_q        <= '0;
      bus.blk_cnt       <= '0;
      bus.frame_done    <= 1'b0;
      bus.overflow_err  <= 1'b0;
      bus.underflow_err <= 1'b0;
    end else begin
      bus.valid_out <= bus.data_valid_in;
      if (bus.data_valid_in) begin
        bus.dout_i <= res_i;
        bus.dout_q <= res_q;
      end
      bus.blk_cnt       <= blk_nxt;
      bus.frame_done    <= bus.data_valid_in && (blk_nxt == BLK_W'(DEPTH-1));
      bus.overflow_err  <= bus.overflow_err |
                           (bus.idx_valid_in && full && !bus.data_valid_in);
      bus.underflow_err <= bus.underflow_err | (bus.data_valid_in && empty);
    end
  end

endmodule

// File: tb/tb_cbfp_index_align.sv
// Scoreboard bench for cbfp_index_align: a queue-based FIFO model and a
// real-valued rounding model predict every output block and sticky flag.
module tb_cbfp_index_align;
  import cbfp_index_align_pkg::*;

  typedef struct {
    dout_vec_t di;
    dout_vec_t dq;
    int        blk;
    bit        frame;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  cbfp_index_align_if bus ();

  cbfp_index_align dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t     exp_q [$];
  idx_vec_t fifo_q[$];
  int       exp_blk = 0;
  bit       exp_ovf = 1'b0;
  bit       exp_unf = 1'b0;
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string name, input logic signed [N*OUT_W-1:0] act,
                       input logic signed [N*OUT_W-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // round(din / 2^tot), halves rounded toward +inf; shifts past the widened width give 0.
  function automatic int ref_lane(input int din, input int tot);
    if (tot == 0)         return din;
    if (tot >= DIN_W + 1) return 0;
    return int'($floor(real'(din) / (2.0 ** tot) + 0.5));
  endfunction

  task automatic model(input bit push, input idx_vec_t i0, input bit dv,
                       input din_vec_t di, input din_vec_t dq, input idx_vec_t i1);
    idx_vec_t h;
    exp_t     e;
    if (dv) begin
      if (fifo_q.size() == 0) begin
        h = '0;
        exp_unf = 1'b1;
      end else begin
        h = fifo_q.pop_front();
      end
      for (int k = 0; k < N; k++) begin
        int tot;
        tot     = int'(h[k]) + int'(i1[k]);
        e.di[k] = OUT_W'(ref_lane(int'($signed(di[k])), tot));
        e.dq[k] = OUT_W'(ref_lane(int'($signed(dq[k])), tot));
      end
      e.blk   = exp_blk;
      e.frame = (exp_blk == DEPTH - 1);
      exp_blk = (exp_blk + 1) % DEPTH;
      exp_q.push_back(e);
    end
    if (push) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(i0);
      else                       exp_ovf = 1'b1;
    end
  endtask

  task automatic set_idle();
    bus.idx_valid_in  = 1'b0;
    bus.idx0_in       = '0;
    bus.data_valid_in = 1'b0;
    bus.din_i         = '0;
    bus.din_q         = '0;
    bus.idx1_in       = '0;
  endtask

  task automatic cycle(input bit push, input idx_vec_t i0, input bit dv,
                       input din_vec_t di, input din_vec_t dq, input idx_vec_t i1);
    @(posedge clk);
    #1;
    bus.idx_valid_in  = push;
    bus.idx0_in       = i0;
    bus.data_valid_in = dv;
    bus.din_i         = di;
    bus.din_q         = dq;
    bus.idx1_in       = i1;
    model(push, i0, dv, di, dq, i1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  function automatic idx_vec_t rand_idx(input int max);
    idx_vec_t v;
    for (int k = 0; k < N; k++) v[k] = IDX_W'($urandom_range(0, max));
    return v;
  endfunction

  function automatic din_vec_t rand_din();
    din_vec_t v;
    for (int k = 0; k < N; k++) v[k] = DIN_W'($urandom);
    return v;
  endfunction

  function automatic idx_vec_t fill_idx(input int val);
    idx_vec_t v;
    for (int k = 0; k < N; k++) v[k] = IDX_W'(val);
    return v;
  endfunction

  function automatic din_vec_t fill_din(input int val);
    din_vec_t v;
    for (int k = 0; k < N; k++) v[k] = DIN_W'(val);
    return v;
  endfunction

  task automatic push_rand();
    cycle(1'b1, rand_idx(7), 1'b0, '0, '0, '0);
  endtask

  task automatic pop_rand();
    cycle(1'b0, '0, 1'b1, rand_din(), rand_din(), rand_idx(7));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    set_idle();
    rstn = 1'b0;
    #1;
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_blk_cnt", bus.blk_cnt, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_overflow", bus.overflow_err, 0);
    check("rst_underflow", bus.underflow_err, 0);
    check("rst_dout_i", bus.dout_i, 0);
    fifo_q.delete();
    exp_q.delete();
    exp_blk = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Monitor: every presented block is matched against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_block", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dout_i", bus.dout_i, e.di);
          check("dout_q", bus.dout_q, e.dq);
          check("blk_cnt", bus.blk_cnt, e.blk);
          check("frame_done", bus.frame_done, e.frame);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    #2;
    do_reset();

    // Basic rounding: idx0 = 3 on every lane.
    cycle(1'b1, fill_idx(3), 1'b0, '0, '0, '0);
    cycle(1'b0, '0, 1'b1, fill_din(100), fill_din(-100), '0);
    idle();
    check("t1_valid", bus.valid_out, 1);
    check("t1_dout_i", $signed(bus.dout_i[0]), 13);
    check("t1_dout_q", $signed(bus.dout_q[5]), -12);

    // Zero shift passes through; a combined shift of 20 clears everything.
    cycle(1'b1, '0, 1'b0, '0, '0, '0);
    cycle(1'b0, '0, 1'b1, fill_din(-4096), fill_din(4095), '0);
    idle();
    check("t2_passthru", $signed(bus.dout_i[9]), -4096);
    cycle(1'b1, fill_idx(10), 1'b0, '0, '0, '0);
    cycle(1'b0, '0, 1'b1, fill_din(4095), fill_din(-4096), fill_idx(10));
    idle();
    check("t2_zero_i", bus.dout_i, 0);
    check("t2_zero_q", bus.dout_q, 0);

    // Random traffic with mixed push/pop overlap.
    for (int i = 0; i < 60; i++) begin
      bit p, d;
      p = ($urandom_range(0, 2) != 0);
      d = (fifo_q.size() > 0) && ($urandom_range(0, 1) != 0);
      cycle(p, rand_idx(7), d, rand_din(), rand_din(), rand_idx(7));
    end
    idle();
    drain();
    check("rand_overflow", bus.overflow_err, exp_ovf);
    check("rand_underflow", bus.underflow_err, exp_unf);

    // Fill, overflow on the 33rd vector, then drain a full frame in order.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push_rand();
    idle();
    check("t3_overflow", bus.overflow_err, exp_ovf);
    for (int i = 0; i < DEPTH; i++) pop_rand();
    idle();
    drain();
    check("t3_underflow", bus.underflow_err, exp_unf);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_rand();
    cycle(1'b1, rand_idx(7), 1'b1, rand_din(), rand_din(), rand_idx(7));
    idle();
    check("t4_overflow", bus.overflow_err, exp_ovf);
    for (int i = 0; i < DEPTH; i++) pop_rand();
    idle();
    check("t4_underflow", bus.underflow_err, exp_unf);

    // Empty read with a same-cycle push; the pushed vector serves the next block.
    cycle(1'b1, rand_idx(7), 1'b1, rand_din(), rand_din(), rand_idx(7));
    idle();
    check("t5_underflow", bus.underflow_err, exp_unf);
    pop_rand();
    idle();
    drain();

    // Reset mid-frame while a block is on the output.
    do_reset();
    pop_rand();
    for (int i = 0; i < 11; i++) push_rand();
    for (int i = 0; i < 4; i++) pop_rand();
    @(posedge clk);
    #1 set_idle();
    #1;
    check("t6_pre_valid", bus.valid_out, 1);
    check("t6_pre_underflow", bus.underflow_err, exp_unf);
    do_reset();
    push_rand();
    pop_rand();
    idle();
    drain();
    check("t6_post_underflow", bus.underflow_err, exp_unf);
    check("t6_post_overflow", bus.overflow_err, exp_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
